// File: rtl/usb_tx_pkg.sv
// Shared types, constants and the CRC-16/USB byte update for the usb_tx_seq transmit path.
package usb_tx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        CRC1 = 2'd2,
        CRC2 = 2'd3
    } usb_tx_state_e;

    localparam logic [15:0] CRC16_POLY_REFL = 16'hA001;
    localparam logic [15:0] CRC16_INIT      = 16'hFFFF;

    // Reflected CRC-16: byte enters at the LSB end, one shift per bit.
    function automatic logic [15:0] crc16_usb_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC16_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/usb_crc16.sv
// Registered CRC-16/USB accumulator: init reloads the seed, en folds one byte in.
module usb_crc16
    import usb_tx_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  data_in,
    output logic [15:0] crc_out
);

    logic [15:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (init) begin
            crc_d = CRC16_INIT;
        end else if (en) begin
            crc_d = crc16_usb_byte(crc_q, data_in);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            crc_q <= CRC16_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_out = crc_q;

endmodule

// File: rtl/usb_tx_seq.sv
// USB-style transmit sequencer: payload pass-through followed by two CRC-16/USB bytes.
// Optional beat-fire history register enabled by defining USB_TX_HIST_EN.
module usb_tx_seq
    import usb_tx_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned MAX_LEN    = 64,
    parameter int unsigned LEN_W      = $clog2(MAX_LEN + 1),
    parameter int unsigned HIST_DEPTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  send_data,
    input  logic [LEN_W-1:0]      len,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  tx_ready,
    output logic                  tx_valid,
    output logic [DATA_W-1:0]     tx_data,
    output logic                  tx_last,
    output logic                  busy,
    output logic [HIST_DEPTH-1:0] hist
);

    if (DATA_W != 8) begin : g_bad_data_w
        $error("usb_tx_seq: only DATA_W=8 is supported");
    end

    localparam logic [LEN_W-1:0] MaxLenW = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] OneW    = LEN_W'(1);

    usb_tx_state_e    state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [15:0]      crc;
    logic             fire;

    assign fire = tx_valid && tx_ready;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (send_data) begin
                    len_d   = (len > MaxLenW) ? MaxLenW : len;
                    cnt_d   = '0;
                    state_d = (len_d != '0) ? DATA : CRC1;
                end
            end
            DATA: begin
                // Exit is decided on the pre-increment count, so cnt never exceeds len_q.
                if (fire) begin
                    cnt_d = cnt_q + OneW;
                    if (cnt_q == len_q - OneW) begin
                        state_d = CRC1;
                    end
                end
            end
            CRC1: if (fire) state_d = CRC2;
            CRC2: if (fire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        tx_valid = 1'b0;
        tx_data  = '0;
        tx_last  = 1'b0;
        in_ready = 1'b0;
        if (!reset) begin
            unique case (state_q)
                IDLE: ;
                DATA: begin
                    tx_valid = in_valid;
                    tx_data  = in_data;
                    in_ready = tx_ready;
                end
                CRC1: begin
                    tx_valid = 1'b1;
                    tx_data  = ~crc[7:0];
                end
                CRC2: begin
                    tx_valid = 1'b1;
                    tx_data  = ~crc[15:8];
                    tx_last  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = !reset && (state_q != IDLE);

    usb_crc16 u_crc (
        .clk     (clk),
        .reset   (reset),
        .init    ((state_q == IDLE) && send_data),
        .en      ((state_q == DATA) && fire),
        .data_in (in_data[7:0]),
        .crc_out (crc)
    );

`ifdef USB_TX_HIST_EN
    logic [HIST_DEPTH-1:0] hist_q;

    if (HIST_DEPTH == 1) begin : g_hist_one
        always_ff @(posedge clk) begin
            if (reset) hist_q <= '0;
            else       hist_q <= fire;
        end
    end else begin : g_hist_shift
        always_ff @(posedge clk) begin
            if (reset) hist_q <= '0;
            else       hist_q <= {hist_q[HIST_DEPTH-2:0], fire};
        end
    end

    assign hist = hist_q;
`else
    assign hist = '0;
`endif

endmodule

// File: tb/tb_usb_tx_seq.sv
// Directed bench for usb_tx_seq: queue-based beat model checked every cycle plus literal CRC pins.
module tb_usb_tx_seq;

    localparam int MAX_LEN    = 64;
    localparam int LEN_W      = 7;
    localparam int HIST_DEPTH = 10;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  send_data = 1'b0;
    logic [LEN_W-1:0]      len = '0;
    logic [7:0]            in_data = '0;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic                  tx_ready = 1'b0;
    logic                  tx_valid;
    logic [7:0]            tx_data;
    logic                  tx_last;
    logic                  busy;
    logic [HIST_DEPTH-1:0] hist;

    usb_tx_seq #(
        .DATA_W     (8),
        .MAX_LEN    (MAX_LEN),
        .HIST_DEPTH (HIST_DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .send_data (send_data),
        .len       (len),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .tx_ready  (tx_ready),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_last   (tx_last),
        .busy      (busy),
        .hist      (hist)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [7:0] d;
        logic       last;
        logic       is_crc;
    } beat_t;

    beat_t      exp_q[$];
    logic [7:0] beat_log[$];
    logic [7:0] pkt_bytes [0:127];
    logic [9:0] hist_m = '0;
    int         pkt_done = 0;
    int         payload_fires = 0;
    logic       acc = 1'b0;
    logic       saw_in_ready = 1'b0;
    logic       f_n;
    logic [15:0] c_n;
    int          n_n;

    // Plain CRC-16/USB over the first n bytes of pkt_bytes, before the final inversion.
    function automatic logic [15:0] ref_crc(input int n);
        logic [15:0] c = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {8'h00, pkt_bytes[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return c;
    endfunction

    always @(negedge clk) begin
        f_n = tx_valid && tx_ready;
        acc = in_valid && in_ready;
        if (in_ready) saw_in_ready = 1'b1;
        if (reset) begin
            chk("rst_tx_valid", tx_valid, 0);
            chk("rst_in_ready", in_ready, 0);
            chk("rst_busy", busy, 0);
        end else if (exp_q.size() == 0) begin
            chk("idle_tx_valid", tx_valid, 0);
            chk("idle_tx_data", tx_data, 0);
            chk("idle_tx_last", tx_last, 0);
            chk("idle_in_ready", in_ready, 0);
            chk("idle_busy", busy, 0);
        end else begin
            chk("act_busy", busy, 1);
            if (!exp_q[0].is_crc) begin
                chk("data_tx_valid", tx_valid, in_valid);
                chk("data_in_ready", in_ready, tx_ready);
                chk("data_tx_last", tx_last, 0);
                if (f_n) chk("data_byte", tx_data, exp_q[0].d);
            end else begin
                chk("crc_tx_valid", tx_valid, 1);
                chk("crc_in_ready", in_ready, 0);
                chk("crc_byte", tx_data, exp_q[0].d);
                chk("crc_tx_last", tx_last, exp_q[0].last);
            end
        end
`ifdef USB_TX_HIST_EN
        chk("hist", hist, hist_m);
`else
        chk("hist_off", hist, 0);
`endif
        if (reset) begin
            exp_q.delete();
            hist_m = '0;
        end else begin
            hist_m = {hist_m[8:0], f_n};
            if (exp_q.size() > 0 && f_n) begin
                beat_log.push_back(tx_data);
                if (!exp_q[0].is_crc) payload_fires++;
                if (exp_q[0].last) pkt_done++;
                void'(exp_q.pop_front());
            end else if (exp_q.size() == 0 && send_data) begin
                n_n = (int'(len) > MAX_LEN) ? MAX_LEN : int'(len);
                for (int i = 0; i < n_n; i++) exp_q.push_back('{pkt_bytes[i], 1'b0, 1'b0});
                c_n = ~ref_crc(n_n);
                exp_q.push_back('{c_n[7:0], 1'b0, 1'b1});
                exp_q.push_back('{c_n[15:8], 1'b1, 1'b1});
            end
        end
    end

    // mode 0: always ready/valid; mode 1: tx_ready 1,0,0,1 and random in_valid gaps.
    task automatic run_pkt(input int n, input int mode, input int abort_after);
        int idx = 0;
        int cyc = 0;
        int start_done = pkt_done;
        logic [3:0] rdy_pat = 4'b1001;
        beat_log.delete();
        saw_in_ready = 1'b0;
        payload_fires = 0;
        @(posedge clk); #1;
        send_data = 1'b1;
        len = LEN_W'(n);
        in_valid = 1'b0;
        tx_ready = 1'b1;
        @(posedge clk); #1;
        send_data = 1'b0;
        while (pkt_done == start_done && cyc < 400) begin
            if (acc) idx++;
            if (abort_after > 0 && idx == abort_after) begin
                reset = 1'b1;
                in_valid = 1'b0;
                @(posedge clk); #1;
                reset = 1'b0;
                chk("abort_tx_valid", tx_valid, 0);
                chk("abort_busy", busy, 0);
                chk("abort_hist", hist, 0);
                return;
            end
            if (mode == 0) begin
                tx_ready = 1'b1;
                in_valid = 1'b1;
            end else begin
                tx_ready = rdy_pat[cyc % 4];
                in_valid = 1'($urandom_range(0, 1));
            end
            in_data = pkt_bytes[idx];
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        chk("pkt_completed", pkt_done - start_done, 1);
    endtask

    task automatic load_123456789();
        for (int i = 0; i < 9; i++) pkt_bytes[i] = 8'h31 + 8'(i);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 128; i++) pkt_bytes[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset_tx_valid", tx_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_in_ready", in_ready, 0);
        chk("reset_hist", hist, 0);

        // Test 1: "123456789" -> C8, B4.
        load_123456789();
        chk("model_crc_check", ref_crc(9) ^ 16'hFFFF, 16'hB4C8);
        run_pkt(9, 0, 0);
        chk("t1_beats", beat_log.size(), 11);
        chk("t1_first", beat_log[0], 8'h31);
        chk("t1_crc_lo", beat_log[9], 8'hC8);
        chk("t1_crc_hi", beat_log[10], 8'hB4);
        chk("t1_busy_after", busy, 0);
`ifdef USB_TX_HIST_EN
        chk("t6_hist_full", hist, 10'h3FF);
`else
        chk("t6_hist_zero", hist, 0);
`endif

        // Test 2: empty payload.
        run_pkt(0, 0, 0);
        chk("t2_beats", beat_log.size(), 2);
        chk("t2_lo", beat_log[0], 8'h00);
        chk("t2_hi", beat_log[1], 8'h00);
        chk("t2_no_in_ready", saw_in_ready, 0);

        // Test 3: stalls and gaps.
        pkt_bytes[0] = 8'hA5; pkt_bytes[1] = 8'h3C; pkt_bytes[2] = 8'hF0; pkt_bytes[3] = 8'h0F;
        run_pkt(4, 1, 0);
        chk("t3_beats", beat_log.size(), 6);
        chk("t3_b0", beat_log[0], 8'hA5);
        chk("t3_b3", beat_log[3], 8'h0F);
        chk("t3_payload", payload_fires, 4);

        // Test 4: oversize len saturates.
        for (int i = 0; i < 128; i++) pkt_bytes[i] = 8'(i * 7 + 1);
        run_pkt(MAX_LEN + 5, 0, 0);
        chk("t4_payload", payload_fires, MAX_LEN);
        chk("t4_beats", beat_log.size(), MAX_LEN + 2);

        // Test 5: reset mid-packet, then a clean packet.
        load_123456789();
        run_pkt(8, 0, 3);
        chk("t5_partial", payload_fires, 3);
        run_pkt(9, 0, 0);
        chk("t5_crc_lo", beat_log[9], 8'hC8);
        chk("t5_crc_hi", beat_log[10], 8'hB4);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
